// File: rtl/button_input.sv
// button_input: synchronises and debounces the active-low push buttons
// and queues press/release events in a small FIFO for the CPU.
module button_input #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 4,
    localparam int BW = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
    input  logic                   clk,
    input  logic                   n_rst_async,
    input  logic [NUM_BUTTONS-1:0] buttons_raw,
    output logic [NUM_BUTTONS-1:0] buttons_state,
    output logic                   event_valid,
    input  logic                   event_ready,
    output logic [BW-1:0]          event_button,
    output logic                   event_pressed,
    output logic                   overflow,
    input  logic                   clear_overflow
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = BW + 1;

    logic [NUM_BUTTONS-1:0] r_sync1;
    logic [NUM_BUTTONS-1:0] r_sync2;
    logic [NUM_BUTTONS-1:0] r_stable;
    logic [NUM_BUTTONS-1:0] r_pend;
    logic [NUM_BUTTONS-1:0] r_dir;
    logic [CW-1:0]          r_cnt [NUM_BUTTONS];
    logic [EW-1:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_rp;
    logic [AW-1:0]          r_wp;
    logic [AW:0]            r_count;
    logic                   r_overflow;

    logic [NUM_BUTTONS-1:0] w_psync;
    logic [NUM_BUTTONS-1:0] w_toggle;
    logic [NUM_BUTTONS-1:0] w_drain;
    logic [BW-1:0]          w_grant;
    logic                   w_any;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_lost;

    assign w_psync       = ~r_sync2;
    assign buttons_state = r_stable;
    assign overflow      = r_overflow;
    assign event_valid   = (r_count != '0);
    assign w_pop         = event_valid && event_ready;
    assign {event_button, event_pressed} = r_mem[r_rp];

    always_comb begin
        w_toggle = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            w_toggle[i] = (w_psync[i] != r_stable[i]) &&
                          (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
        end
    end

    // Descending scan so the lowest-index pending button wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_any   = 1'b1;
                w_grant = BW'(i);
            end
        end
    end

    assign w_push  = w_any && ((r_count != (AW+1)'(FIFO_DEPTH)) || w_pop);
    assign w_drain = w_push ? (NUM_BUTTONS'(1) << w_grant) : '0;
    assign w_lost  = |(w_toggle & r_pend & ~w_drain);

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_stable <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1  <= buttons_raw;
            r_sync2  <= r_sync1;
            r_stable <= r_stable ^ w_toggle;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if ((w_psync[i] == r_stable[i]) || w_toggle[i])
                    r_cnt[i] <= '0;
                else
                    r_cnt[i] <= r_cnt[i] + CW'(1);
            end
        end
    end

    // A fresh toggle beats a same-cycle drain of the same button.
    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            r_pend <= '0;
            r_dir  <= '0;
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (w_toggle[i]) begin
                    r_pend[i] <= 1'b1;
                    r_dir[i]  <= ~r_stable[i];
                end else if (w_drain[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            r_rp    <= '0;
            r_wp    <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= {w_grant, r_dir[w_grant]};
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) r_rp <= r_rp + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async)        r_overflow <= 1'b0;
        else if (w_lost)         r_overflow <= 1'b1;
        else if (clear_overflow) r_overflow <= 1'b0;
    end
endmodule

// File: doc/button_input.md
# button_input

Debounces and synchronises the board's active-low push buttons and presents press/release events to the CPU through a small FIFO with a valid/ready handshake. It is the input-direction counterpart of the VGA and buzzer output paths. It sits in `vgacpu_top` on the 50 MHz `clk_50` domain, between the raw button pins and the CPU's I/O interface. It also exposes the current debounced level of every button for polling.

## Interface
- `NUM_BUTTONS`, default 4: number of button inputs (1..16).
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz). Must be ≥2.
- `FIFO_DEPTH`, default 4: event FIFO entries, power of two ≥2.
- `clk`, in, 1: system clock (50 MHz).
- `n_rst_async`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `buttons_raw`, in, `NUM_BUTTONS`: raw pins, active-low (0 = pressed), asynchronous to `clk`.
- `buttons_state`, out, `NUM_BUTTONS`: debounced level, 1 = pressed.
- `event_valid`, out, 1: FIFO head holds an event.
- `event_ready`, in, 1: CPU consumes the head when high with `event_valid`.
- `event_button`, out, `$clog2(NUM_BUTTONS)` (min 1): button index of the head event.
- `event_pressed`, out, 1: 1 = press, 0 = release.
- `overflow`, out, 1: sticky; an event was lost.
- `clear_overflow`, in, 1: clears `overflow` on the next edge.

## Operation
- **Synchroniser:** two flops per button, reset to 1 (released). The output of the second flop, `sync`, is inverted to get `pressed_sync`.
- **Debounce, per button:**
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `pressed_sync == stable`, the counter clears to 0.
  - Otherwise the counter increments. On the cycle it would reach `DEBOUNCE_CYCLES`, `stable` toggles and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `stable`.
  - `buttons_state = stable`.
- **Change capture:**
  - When `stable[i]` toggles, `pend[i]` is set to 1 and `pend_dir[i]` is set to the new level.
  - If `pend[i]` is already 1 and not being drained that cycle, the older event is overwritten by the newer one and `overflow` is set.
- **Arbiter:** each cycle, the lowest-index set `pend[i]` is pushed into the FIFO as `{i, pend_dir[i]}` and `pend[i]` clears. At most one push per cycle.
  - A push is allowed when FIFO count < `FIFO_DEPTH`, or when a pop occurs the same cycle.
  - If neither holds, `pend` is held. No loss occurs at this stage.
  - A pend set and drained in the same cycle for the same button: the set wins, the new event stays pending, and the drained one is pushed.
- **FIFO:** circular buffer with read pointer, write pointer and count.
  - `event_valid = (count != 0)`.
  - `event_button` and `event_pressed` are driven combinationally from the entry at the read pointer.
  - A pop happens on `event_valid && event_ready`. `event_ready` while empty is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Overflow:**
  - Set by a pend overwrite.
  - Cleared by `clear_overflow`, except that set wins if both occur in the same cycle.

## Timing
- **Reset values** (asynchronous, on `n_rst_async = 0`):
  - `buttons_state = 0`, `event_valid = 0`, `event_button = 0`, `event_pressed = 0`, `overflow = 0`.
  - Counters, pend bits and pointers are all 0; synchronisers are all 1.
  - Reset mid-debounce or with a non-empty FIFO discards everything.
  - After release, a button held down produces a press event only after the full debounce delay.
- **Latency**, for a raw change that stays steady, with the change registered at edge 0:
  - `pressed_sync` changes at edge 2.
  - `stable`/`buttons_state` changes at edge 2 + `DEBOUNCE_CYCLES`.
  - The FIFO push happens at the next edge, so `event_valid` rises after edge 3 + `DEBOUNCE_CYCLES` (FIFO empty, no lower-index pend).
- **Pop:** the head advances on the edge where `valid && ready`. A new head is visible the following cycle. Back-to-back pops are sustained at one per cycle.
- **Simultaneous push and pop when full:** both occur and count is unchanged.
- **Simultaneous toggles on several buttons:** pushed on consecutive cycles in ascending index order.

## Test plan
Parameters for the bench: `NUM_BUTTONS=4`, `DEBOUNCE_CYCLES=8`, `FIFO_DEPTH=4`.
1. **Single press:** drive `buttons_raw[2]` to 0 and hold from edge 0 → `buttons_state=4'b0100` at edge 10. `event_valid` goes high after edge 11 with `event_button=2`, `event_pressed=1`. Pulse `event_ready` → `event_valid=0` next cycle.
2. **Bounce rejection:** toggle `buttons_raw[0]` low for 5 cycles, high for 2, low for 5, then high → `buttons_state` stays 0, `event_valid` never rises, `overflow=0`.
3. **Simultaneous press:** drive `buttons_raw=4'b0000` in one cycle with `event_ready=0` → four events in order (0,1), (1,1), (2,1), (3,1), pushed on four consecutive cycles. A FIFO read then returns that order.
4. **Full and overflow:** with `event_ready=0`:
   - Press and release button 1 twice, producing 4 queued events.
   - Then press button 1 again, giving pending event 5, then release it, giving event 6, which overwrites event 5 → `overflow=1`, FIFO count 4.
   - Pop all with `event_ready=1` → returns (1,1),(1,0),(1,1),(1,0), then (1,0) from the pending event.
   - Pulse `clear_overflow` → `overflow=0`.
5. **Push and pop while full:** with the FIFO full and one event pending, hold `event_ready=1` → one pop and one push on the same edge, count stays 4 for that cycle, no loss.
6. **Reset mid-operation:** assert `n_rst_async` low asynchronously with 3 events queued and button 3 mid-debounce → all outputs 0 immediately. After release with button 3 still held, a press event appears 11 edges later.
